// File: rtl/mem_dma_engine_pkg.sv
// Shared definitions for the DataMem block-transfer engine:
// memory opcodes, transfer modes and engine state encoding.
package mem_dma_engine_pkg;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    localparam logic [5:0] OP_LDW = 6'h23;
    localparam logic [5:0] OP_SDW = 6'h2b;

    localparam logic DMA_COPY = 1'b0;
    localparam logic DMA_FILL = 1'b1;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RD   = 2'd1,
        DMA_WR   = 2'd2
    } dma_state_t;

endpackage

// File: rtl/mem_dma_engine.sv
// Block COPY/FILL engine owning the DataMem port while busy.
// Idle: MEM-stage signals pass straight through to memory.
module mem_dma_engine
    import mem_dma_engine_pkg::*;
#(
    parameter int DEPTH = mem_dma_engine_pkg::DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          mode,
    input  logic [31:0]   src,
    input  logic [31:0]   dst,
    input  logic [AW:0]   len,
    input  logic [31:0]   fill_val,
    output logic          busy,
    output logic          done,
    output logic          stall,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_data,
    input  logic [5:0]    cpu_opcode,
    output logic [31:0]   cpu_rdata,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [5:0]    mem_opcode,
    input  logic [31:0]   mem_rdata
);

    dma_state_t      state, state_nx;
    logic            mode_q;
    logic [AW-1:0]   src_q, dst_q, idx;
    logic [AW:0]     len_q;
    logic [31:0]     fill_q, buffer;
    logic            last;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic            unused_hi;

    assign unused_hi = ^{src[31:AW], dst[31:AW]};

    assign last    = ({1'b0, idx} == len_q - 1'b1);
    assign rd_addr = src_q + idx;
    assign wr_addr = dst_q + idx;

    assign busy      = (state != DMA_IDLE);
    assign stall     = busy;
    assign cpu_rdata = mem_rdata;

    // State register, transfer context, index, read buffer, done pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= DMA_IDLE;
            mode_q <= DMA_COPY;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            idx    <= '0;
            buffer <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                DMA_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        src_q  <= src[AW-1:0];
                        dst_q  <= dst[AW-1:0];
                        len_q  <= len;
                        fill_q <= fill_val;
                        idx    <= '0;
                        if (len == '0)
                            done <= 1'b1;
                    end
                end
                DMA_RD: buffer <= mem_rdata;
                DMA_WR: begin
                    if (last)
                        done <= 1'b1;
                    else
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and memory-port mux
    always_comb begin
        state_nx   = state;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_data;
        mem_opcode = cpu_opcode;
        unique case (state)
            DMA_IDLE: begin
                if (start && len != '0)
                    state_nx = (mode == DMA_FILL) ? DMA_WR : DMA_RD;
            end
            DMA_RD: begin
                mem_addr   = {{(32-AW){1'b0}}, rd_addr};
                mem_wdata  = buffer;
                mem_opcode = OP_LDW;
                state_nx   = DMA_WR;
            end
            DMA_WR: begin
                mem_addr   = {{(32-AW){1'b0}}, wr_addr};
                mem_wdata  = (mode_q == DMA_FILL) ? fill_q : buffer;
                mem_opcode = OP_SDW;
                if (last)
                    state_nx = DMA_IDLE;
                else
                    state_nx = (mode_q == DMA_FILL) ? DMA_WR : DMA_RD;
            end
            default: state_nx = DMA_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Testbench for mem_dma_engine with a behavioural DataMem
// (combinational read, negedge store) preloaded with mem[i]=i+6.
module tb_mem_dma_engine;
    import mem_dma_engine_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src = '0, dst = '0, fill_val = '0;
    logic [8:0]  len = '0;
    logic        busy, done, stall;
    logic [31:0] cpu_addr = '0, cpu_data = '0;
    logic [5:0]  cpu_opcode = '0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [5:0]  mem_opcode;

    logic [31:0] mem [0:255];

    int passed = 0;
    int total  = 0;

    mem_dma_engine dut (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .stall(stall),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_opcode(cpu_opcode), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_opcode(mem_opcode), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr[7:0]];

    // DataMem store on the falling edge
    always @(negedge CLK) begin
        if (mem_opcode == OP_SDW)
            mem[mem_addr[7:0]] <= mem_wdata;
    end

    typedef struct {
        logic        m;
        int          s, d, l;
        logic [31:0] f;
        int          kick, rst_at;
        int          exp_busy, exp_done;
    } vec_t;

    typedef struct {
        int          v;
        int          a;
        logic [31:0] d;
    } mchk_t;

    vec_t  vt [6];
    mchk_t mc [$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++)
            mem[i] = i + 6;
    endtask

    task automatic run(input vec_t v, output int nb, output int nd,
                       output logic hi, output logic sdw,
                       output logic to);
        nb = 0; nd = 0; hi = 0; sdw = 0; to = 1;
        mode = v.m; src = v.s; dst = v.d;
        len = v.l[8:0]; fill_val = v.f;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 2 * v.l + 10; c++) begin
            if (c == v.kick) begin
                start = 1'b1; len = 9'd2; dst = 60;
                cpu_opcode = OP_SDW; cpu_addr = 50;
                cpu_data = 32'hBAD;
            end
            if (c == v.kick + 1)
                start = 1'b0;
            if (c == v.rst_at) begin
                RST = 1'b1;
                #1;
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_stall", {31'd0, stall}, 32'd0);
                check("rst_pass", mem_addr, cpu_addr);
                RST = 1'b0;
                to = 0;
                break;
            end
            if (busy) begin
                nb++;
                if (mem_addr[31:8] != 0) hi = 1;
            end else begin
                cpu_opcode = '0;
            end
            if (mem_opcode == OP_SDW) sdw = 1;
            if (done) begin
                nd++;
                to = 0;
                break;
            end
            tick();
        end
        cpu_opcode = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (busy) nb++;
            if (done) nd++;
        end
    endtask

    initial begin
        int   nb, nd;
        logic hi, sdw, to;

        vt[0] = '{DMA_COPY, 0, 100, 4, 32'h0, -1, -1, 8, 1};
        vt[1] = '{DMA_FILL, 0, 10, 3, 32'hDEAD, -1, -1, 3, 1};
        vt[2] = '{DMA_FILL, 0, 254, 4, 32'h7, -1, -1, 4, 1};
        vt[3] = '{DMA_COPY, 0, 100, 0, 32'h0, -1, -1, 0, 1};
        vt[4] = '{DMA_COPY, 20, 30, 5, 32'h0, 3, -1, 10, 1};
        vt[5] = '{DMA_COPY, 0, 200, 8, 32'h0, -1, 5, 4, 0};

        mc.push_back('{0, 100, 6});
        mc.push_back('{0, 101, 7});
        mc.push_back('{0, 102, 8});
        mc.push_back('{0, 103, 9});
        mc.push_back('{0, 0, 6});
        mc.push_back('{0, 3, 9});
        mc.push_back('{1, 10, 32'hDEAD});
        mc.push_back('{1, 11, 32'hDEAD});
        mc.push_back('{1, 12, 32'hDEAD});
        mc.push_back('{1, 9, 15});
        mc.push_back('{1, 13, 19});
        mc.push_back('{2, 254, 7});
        mc.push_back('{2, 255, 7});
        mc.push_back('{2, 0, 7});
        mc.push_back('{2, 1, 7});
        mc.push_back('{2, 2, 8});
        mc.push_back('{3, 100, 106});
        mc.push_back('{4, 30, 26});
        mc.push_back('{4, 32, 28});
        mc.push_back('{4, 34, 30});
        mc.push_back('{4, 35, 41});
        mc.push_back('{4, 50, 56});
        mc.push_back('{4, 60, 66});
        mc.push_back('{5, 200, 6});
        mc.push_back('{5, 201, 7});
        for (int a = 203; a <= 207; a++)
            mc.push_back('{5, a, a + 6});

        preload();
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        RST = 1'b0;
        cpu_addr = 5;
        #1;
        check("idle_addr", mem_addr, 32'd5);
        check("idle_rdata", cpu_rdata, 32'd11);
        cpu_addr = 0;
        tick();

        for (int i = 0; i < 6; i++) begin
            preload();
            run(vt[i], nb, nd, hi, sdw, to);
            check($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
            check($sformatf("v%0d_busy", i), nb, vt[i].exp_busy);
            check($sformatf("v%0d_done", i), nd, vt[i].exp_done);
            check($sformatf("v%0d_hiaddr", i), {31'd0, hi}, 32'd0);
            check($sformatf("v%0d_sdw", i), {31'd0, sdw},
                  {31'd0, vt[i].l != 0});
            foreach (mc[j])
                if (mc[j].v == i)
                    check($sformatf("v%0d_mem%0d", i, mc[j].a),
                          mem[mc[j].a], mc[j].d);
        end

        cpu_addr = 5;
        cpu_opcode = '0;
        #1;
        check("post_rst_addr", mem_addr, 32'd5);
        check("post_rst_rdata", cpu_rdata, 32'd11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
